mat_product_gen: RTL
====================

// Module: mat_product_gen
// PURPOSE
//  Upstream stage of the 4x4 matrix-multiply datapath. Latches two 4x4 unsigned
//  matrices A and B and computes all 64 partial products A[i][k]*B[k][j].
//  Only NMUL multipliers are instantiated, so the products are computed over
//  64/NMUL cycles. The packed 64-product bus feeds the 4-way summing stage,
//  which adds consecutive groups of 4 products to form C[i][j].
// PARAMETERS
//  DW    8   operand element width, unsigned
//  PW    18  product lane width; must satisfy PW >= 2*DW+2 (sum of 4 never overflows)
//  NMUL  4   multipliers used per cycle; legal values 1,2,4,8,16,32,64
// PORTS
//  clk      in   1        clock, all logic on rising edge
//  reset    in   1        synchronous, active-high reset
//  start    in   1        request; accepted only in IDLE
//  A_in     in   16*DW    A[i][k] at A_in[(i*4+k)*DW +: DW]
//  B_in     in   16*DW    B[k][j] at B_in[(k*4+j)*DW +: DW]
//  busy     out  1        high whenever state != IDLE
//  valid    out  1        products complete and stable
//  ready    in   1        downstream accepts products
//  P_out    out  64*PW    product p at P_out[p*PW +: PW], p = i*16 + j*4 + k
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, busy=0, valid=0, P_out=0, operand registers=0.
//    Reset wins over every other input, including mid-operation; no partial
//    result survives.
//  FSM states: IDLE, MULT, DONE.
//   IDLE -> MULT on start=1.
//     Same edge: A_in and B_in are latched into internal registers and cnt=0.
//     Later changes on A_in/B_in have no effect.
//   MULT: on each edge, lanes m=0..NMUL-1 compute p = cnt*NMUL + m.
//     Product is P_out[p] = zext(A[i][k]*B[k][j]).
//     i = p/16, j = (p/4)%4, k = p%4.
//     cnt increments.
//     When cnt = 64/NMUL-1, that edge writes the last products and moves to DONE.
//   DONE: valid=1; P_out is held constant.
//     On ready=1, the next edge moves to IDLE with valid=0.
//  Latency: valid rises exactly 64/NMUL cycles after the start-accept edge
//    (16 cycles at NMUL=4). While ready stays high, the next start can be
//    accepted 64/NMUL+2 cycles after the previous one.
//  start while busy=1 is ignored, not queued. This includes start arriving in
//    DONE in the same cycle as ready.
//  ready outside DONE is ignored.
//  P_out lanes change during MULT. Consumers must qualify them with valid.
//    Lanes not yet written keep their values from the previous operation.
//  Arithmetic: unsigned DW x DW -> 2*DW bits, zero-extended to PW. No rounding,
//    no saturation.
//  Elaboration must fail (generate-time $error) if NMUL does not divide 64
//    or PW < 2*DW+2.
// TESTING
//  1. A=identity, B[k][j]=4k+j+1, start -> valid at +16 cycles.
//     P_out[i*16+j*4+k] = (i==k) ? 4k+j+1 : 0.
//  2. A=B all 8'hFF -> every lane = 18'h0FE01.
//     A 4-lane sum from the downstream stage = 18'h3F804, with no overflow.
//  3. start pulsed again at cycles +3 and +16 (DONE) -> ignored.
//     Exactly one valid window; operands unchanged.
//  4. ready held low 5 cycles after valid -> valid and P_out stable for 5 cycles.
//     ready=1 -> IDLE next edge.
//  5. reset asserted at cnt=7 -> next edge: busy=0, valid=0, P_out=0.
//     A fresh start completes normally.
//  6. NMUL=1 and NMUL=64 builds, random matrices -> latency of 64 and 1 cycles.
//     All 64 lanes match the reference model.

Source files
------------

// File: rtl/mat_product_gen.sv
// mat_product_gen
//   Front end of the 4x4 matrix-multiply datapath. Captures two 4x4 unsigned
//   matrices A and B on an accepted start, then forms all 64 partial products
//   A[i][k]*B[k][j] using NMUL multipliers per cycle (64/NMUL cycles total).
//   Product p = i*16 + j*4 + k, so each run of 4 consecutive lanes sums to
//   one C[i][j] in the downstream adder stage.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   start  in   operation request, honoured only when idle
//   A_in   in   A[i][k] at A_in[(i*4+k)*DW +: DW]
//   B_in   in   B[k][j] at B_in[(k*4+j)*DW +: DW]
//   busy   out  high whenever not idle
//   valid  out  all 64 products complete and held
//   ready  in   downstream accepts the products (only looked at in DONE)
//   P_out  out  product p at P_out[p*PW +: PW]
//
// state | meaning
// IDLE  | waiting for start; operands may change freely
// MULT  | NMUL products per cycle, cnt selects the lane group
// DONE  | valid high, products frozen until ready
module mat_product_gen #(
  parameter int DW   = 8,
  parameter int PW   = 18,
  parameter int NMUL = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [16*DW-1:0] A_in,
  input  logic [16*DW-1:0] B_in,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [64*PW-1:0] P_out
);

  localparam int NCYC = 64 / NMUL;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  if ((64 % NMUL) != 0 || PW < 2*DW + 2) begin : g_param_err
    $error("mat_product_gen: NMUL must divide 64 and PW must be >= 2*DW+2");
  end

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            valid_q;
  logic [DW-1:0]   a_q [16];
  logic [DW-1:0]   b_q [16];
  logic [PW-1:0]   p_q [64];

  logic [5:0]      lane_idx  [NMUL];
  logic [2*DW-1:0] lane_prod [NMUL];

  // Lane m handles product p = cnt*NMUL + m. With p = i*16 + j*4 + k the
  // A element index i*4+k is {p[5:4],p[1:0]} and the B index k*4+j is
  // {p[1:0],p[3:2]}. At NMUL=64 the 6-bit cast of NMUL wraps to 0, which is
  // harmless because cnt never leaves 0 there.
  for (genvar m = 0; m < NMUL; m++) begin : g_lane
    assign lane_idx[m]  = 6'(cnt_q) * 6'(NMUL) + 6'(m);
    assign lane_prod[m] = (2*DW)'(a_q[{lane_idx[m][5:4], lane_idx[m][1:0]}])
                        * (2*DW)'(b_q[{lane_idx[m][1:0], lane_idx[m][3:2]}]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int e = 0; e < 16; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
      for (int p = 0; p < 64; p++) p_q[p] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int e = 0; e < 16; e++) begin
              a_q[e] <= A_in[e*DW +: DW];
              b_q[e] <= B_in[e*DW +: DW];
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MULT;
          end
        end
        MULT: begin
          for (int m = 0; m < NMUL; m++) p_q[lane_idx[m]] <= PW'(lane_prod[m]);
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          // start is deliberately not examined here, even alongside ready
          if (ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

  for (genvar p = 0; p < 64; p++) begin : g_pack
    assign P_out[p*PW +: PW] = p_q[p];
  end

endmodule
